// File: rtl/led_write_arbiter_if.sv
// rtl/led_write_arbiter_if.sv - requester handshake and LED write bus signals
interface led_write_arbiter_if;
  logic [1:0] REQ_VALID;
  logic [1:0] REQ_LOCK;
  logic [7:0] REQ0_ADDR;
  logic [7:0] REQ0_DATA;
  logic [7:0] REQ1_ADDR;
  logic [7:0] REQ1_DATA;
  logic [1:0] REQ_READY;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA;
  logic       BUS_WE;
  logic       ADDR_ERR;

  // Requester side: presents writes, observes ready and the registered bus.
  modport master (
    output REQ_VALID, REQ_LOCK, REQ0_ADDR, REQ0_DATA, REQ1_ADDR, REQ1_DATA,
    input  REQ_READY, BUS_ADDR, BUS_DATA, BUS_WE, ADDR_ERR
  );

  // Arbiter side.
  modport slave (
    input  REQ_VALID, REQ_LOCK, REQ0_ADDR, REQ0_DATA, REQ1_ADDR, REQ1_DATA,
    output REQ_READY, BUS_ADDR, BUS_DATA, BUS_WE, ADDR_ERR
  );
endinterface

// File: rtl/led_write_arbiter.sv
// rtl/led_write_arbiter.sv - round-robin two-requester LED write arbiter with lock; optional LED_ARB_STATS_EN grant counters
module led_write_arbiter #(
  parameter logic [7:0] LedBaseAddress = 8'hC0,
  parameter int         MaxLockBeats   = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  led_write_arbiter_if.slave bus
`ifdef LED_ARB_STATS_EN
  ,
  input  logic               STATS_CLR,
  output logic [7:0]         GRANT_CNT0,
  output logic [7:0]         GRANT_CNT1
`endif
);

  localparam logic [7:0] LedLastAddress = LedBaseAddress + 8'd1;
  localparam logic [3:0] MaxBeats       = 4'(MaxLockBeats);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic [7:0] bus_addr_q, bus_addr_d;
  logic [7:0] bus_data_q, bus_data_d;
  logic       bus_we_q, bus_we_d;
  logic       addr_err_q, addr_err_d;

  logic [1:0] ready;
  logic       xfer;
  logic       win;
  logic       win_lock;
  logic [7:0] win_addr;
  logic [7:0] win_data;
  logic       in_window;

  // Grant selection: round-robin in ARB, only the lock holder while locked.
  always_comb begin
    ready = 2'b00;
    case (state_q)
      ST_ARB: begin
        if (bus.REQ_VALID == 2'b11) begin
          ready = last_grant_q ? 2'b01 : 2'b10;
        end else begin
          ready = bus.REQ_VALID;
        end
      end
      ST_LOCK0: ready = {1'b0, bus.REQ_VALID[0]};
      ST_LOCK1: ready = {bus.REQ_VALID[1], 1'b0};
      default:  ready = 2'b00;
    endcase
  end

  assign xfer      = |ready;
  assign win       = ready[1];
  assign win_lock  = bus.REQ_LOCK[win];
  assign win_addr  = win ? bus.REQ1_ADDR : bus.REQ0_ADDR;
  assign win_data  = win ? bus.REQ1_DATA : bus.REQ0_DATA;
  assign in_window = (win_addr == LedBaseAddress) || (win_addr == LedLastAddress);

  assign bus.REQ_READY = ready;
  assign bus.BUS_ADDR  = bus_addr_q;
  assign bus.BUS_DATA  = bus_data_q;
  assign bus.BUS_WE    = bus_we_q;
  assign bus.ADDR_ERR  = addr_err_q;

  // Next state: enter lock on a locking win, leave on unlock or beat limit.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    if (xfer) begin
      last_grant_d = win;
      if (state_q == ST_ARB) begin
        if (win_lock && (MaxBeats > 4'd1)) begin
          state_d    = win ? ST_LOCK1 : ST_LOCK0;
          lock_cnt_d = 4'd1;
        end
      end else if (!win_lock || ((lock_cnt_q + 4'd1) >= MaxBeats)) begin
        state_d    = ST_ARB;
        lock_cnt_d = 4'd0;
      end else begin
        lock_cnt_d = lock_cnt_q + 4'd1;
      end
    end
  end

  // Bus stage: forward in-window writes, flag out-of-window ones and hold the bus.
  always_comb begin
    bus_we_d   = 1'b0;
    addr_err_d = 1'b0;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    if (xfer) begin
      if (in_window) begin
        bus_we_d   = 1'b1;
        bus_addr_d = win_addr;
        bus_data_d = win_data;
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  // Arbitration and bus registers; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_ARB;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= 4'd0;
      bus_addr_q   <= 8'h00;
      bus_data_q   <= 8'h00;
      bus_we_q     <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      bus_addr_q   <= bus_addr_d;
      bus_data_q   <= bus_data_d;
      bus_we_q     <= bus_we_d;
      addr_err_q   <= addr_err_d;
    end
  end

`ifdef LED_ARB_STATS_EN
  logic [7:0] grant_cnt0_q, grant_cnt0_d;
  logic [7:0] grant_cnt1_q, grant_cnt1_d;

  // Saturating per-requester accept counters; clear beats a same-cycle increment.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (STATS_CLR) begin
      grant_cnt0_d = 8'h00;
      grant_cnt1_d = 8'h00;
    end else if (xfer) begin
      if (!win && (grant_cnt0_q != 8'hFF)) grant_cnt0_d = grant_cnt0_q + 8'd1;
      if (win && (grant_cnt1_q != 8'hFF)) grant_cnt1_d = grant_cnt1_q + 8'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      grant_cnt0_q <= 8'h00;
      grant_cnt1_q <= 8'h00;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign GRANT_CNT0 = grant_cnt0_q;
  assign GRANT_CNT1 = grant_cnt1_q;
`endif

endmodule
